// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the mux scan sampler: FSM encoding, channel count
// and the dwell-counter width helper.
package mux_scan_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_CH = 4;

  // Counter width for a given dwell: ceil(log2(dwell)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned dwell);
    return (dwell < 2) ? 1 : int'($clog2(dwell));
  endfunction

endpackage

// File: rtl/mux_scan_sampler_dwell_counter.sv
// Dwell counter: counts cycles spent on one mux channel and flags the last
// one. Clear has priority over enable.
module dwell_counter
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear, advance, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// Mux scan sampler: steps the mux select through all channels, waits DWELL
// cycles on each, samples the mux output and publishes the whole word at once.
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] data,
  output logic       valid
);

  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       cnt_clr, cnt_en, cnt_tc;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Scan sequencing: channel stepping, sample capture and result publishing.
  // The last channel's sample goes straight into data alongside the shadow
  // bits, so data is only ever replaced as a complete word.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          sel_d   = '0;
        end
      end
      SCAN: begin
        cnt_clr = cnt_tc;
        cnt_en  = !cnt_tc;
        if (cnt_tc) begin
          if (sel_q != LAST_CH) begin
            shadow_d[sel_q] = mux_out;
            sel_d           = sel_q + 2'd1;
          end else begin
            data_d  = {mux_out, shadow_q};
            valid_d = 1'b1;
            sel_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        sel_d   = '0;
        state_d = (cont || start) ? SCAN : IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State, select, shadow and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign busy  = (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler: a DWELL=4 and a DWELL=1 build,
// each driven by a behavioural 4:1 mux, with a per-build result scoreboard.
module tb_mux_scan_sampler;

  logic clk;
  logic rst_n;

  logic       start_a, cont_a;
  logic [3:0] in_a;
  logic       mux_a;
  logic [1:0] sel_a;
  logic       busy_a, done_a, valid_a;
  logic [3:0] data_a;

  logic       start_b, cont_b;
  logic [3:0] in_b;
  logic       mux_b;
  logic [1:0] sel_b;
  logic       busy_b, done_b, valid_b;
  logic [3:0] data_b;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned done_cnt_a = 0;
  int unsigned done_cnt_b = 0;
  logic [3:0]  q_a[$];
  logic [3:0]  q_b[$];
  logic [3:0]  model_a;
  logic        vmodel_a;

  assign mux_a = in_a[sel_a];
  assign mux_b = in_b[sel_b];

  mux_scan_sampler #(.DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .mux_out(mux_a),
    .sel(sel_a), .busy(busy_a), .done(done_a), .data(data_a), .valid(valid_a)
  );

  mux_scan_sampler #(.DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .mux_out(mux_b),
    .sel(sel_b), .busy(busy_b), .done(done_b), .data(data_b), .valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the DWELL=4 build: every done pulse retires one expected word.
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      chk("sb_a_queued", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) begin
        chk("sb_a_data", 32'(data_a), 32'(q_a.pop_front()));
        chk("sb_a_valid", 32'(valid_a), 32'd1);
      end
    end
  end

  // Scoreboard for the DWELL=1 build.
  always @(negedge clk) begin
    if (done_b) begin
      done_cnt_b++;
      chk("sb_b_queued", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) chk("sb_b_data", 32'(data_b), 32'(q_b.pop_front()));
    end
  end

  // One DWELL=4 scan started at edge 0; optionally re-pulses start mid-scan.
  task automatic scan_a(input logic [3:0] pat, input bit poke);
    int unsigned dc0;
    dc0 = done_cnt_a;
    in_a = pat;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    q_a.push_back(pat);
    for (int e = 0; e < 18; e++) begin
      start_a = (poke && (e == 4 || e == 8)) ? 1'b1 : 1'b0;
      chk($sformatf("sel@%0d", e),   32'(sel_a),   (e < 16) ? 32'(e / 4) : 32'd0);
      chk($sformatf("busy@%0d", e),  32'(busy_a),  32'(e < 16));
      chk($sformatf("done@%0d", e),  32'(done_a),  32'(e == 16));
      chk($sformatf("data@%0d", e),  32'(data_a),  (e < 16) ? 32'(model_a) : 32'(pat));
      chk($sformatf("valid@%0d", e), 32'(valid_a), (e < 16) ? 32'(vmodel_a) : 32'd1);
      tick();
    end
    start_a = 1'b0;
    model_a = pat;
    vmodel_a = 1'b1;
    chk("done_count", done_cnt_a - dc0, 32'd1);
  endtask

  initial begin
    int unsigned dc0;
    rst_n = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; in_a = '0;
    start_b = 1'b0; cont_b = 1'b0; in_b = '0;
    model_a = '0; vmodel_a = 1'b0;

    // Reset state
    #2;
    chk("rst_sel",   32'(sel_a),   32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_data",  32'(data_a),  32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic scan
    scan_a(4'b1010, 1'b0);

    // start pulses while busy are ignored
    scan_a(4'b0110, 1'b1);

    // Asynchronous reset mid-scan
    dc0 = done_cnt_a;
    in_a = 4'b1111;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel",   32'(sel_a),   32'd0);
    chk("mid_rst_busy",  32'(busy_a),  32'd0);
    chk("mid_rst_done",  32'(done_a),  32'd0);
    chk("mid_rst_data",  32'(data_a),  32'd0);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    model_a = '0;
    vmodel_a = 1'b0;
    repeat (20) tick();
    chk("mid_rst_no_done", done_cnt_a - dc0, 32'd0);
    chk("mid_rst_idle",    32'(busy_a),      32'd0);
    scan_a(4'b1111, 1'b0);

    // Continuous mode; cont dropped mid second scan still completes it
    dc0 = done_cnt_a;
    in_a = 4'b0001;
    cont_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    q_a.push_back(4'b0001);
    for (int e = 0; e < 36; e++) begin
      if (e == 16) begin
        in_a = 4'b1000;
        q_a.push_back(4'b1000);
        chk("cont_data1", 32'(data_a), 32'h1);
      end
      if (e == 20) cont_a = 1'b0;
      if (e == 33) chk("cont_data2", 32'(data_a), 32'h8);
      chk($sformatf("cont_busy@%0d", e), 32'(busy_a), 32'((e < 16) || (e >= 17 && e < 33)));
      chk($sformatf("cont_done@%0d", e), 32'(done_a), 32'(e == 16 || e == 33));
      chk($sformatf("cont_sel@%0d", e), 32'(sel_a),
          (e < 16) ? 32'(e / 4) : ((e >= 17 && e < 33) ? 32'((e - 17) / 4) : 32'd0));
      tick();
    end
    chk("cont_done_count", done_cnt_a - dc0, 32'd2);
    model_a = 4'b1000;

    // Exhaustive sweep
    for (int p = 0; p < 16; p++) begin
      scan_a(4'(p), 1'b0);
      chk($sformatf("sweep_valid_%0d", p), 32'(valid_a), 32'd1);
    end

    // DWELL=1 build
    dc0 = done_cnt_b;
    in_b = 4'b0101;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    q_b.push_back(4'b0101);
    for (int e = 0; e < 6; e++) begin
      chk($sformatf("b_sel@%0d", e),  32'(sel_b),  (e < 4) ? 32'(e) : 32'd0);
      chk($sformatf("b_busy@%0d", e), 32'(busy_b), 32'(e < 4));
      chk($sformatf("b_done@%0d", e), 32'(done_b), 32'(e == 4));
      chk($sformatf("b_data@%0d", e), 32'(data_b), (e < 4) ? 32'd0 : 32'h5);
      chk($sformatf("b_valid@%0d", e), 32'(valid_b), 32'(e >= 4));
      tick();
    end
    chk("b_done_count", done_cnt_b - dc0, 32'd1);

    chk("sb_a_empty", 32'(q_a.size()), 32'd0);
    chk("sb_b_empty", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
